// File: rtl/comb_sched_pkg.sv
// Shared types and constants for the comb_sched round-robin scheduler.
// The state encoding is fixed; the unused code 2'd3 recovers to IDLE.
package comb_sched_pkg;

    localparam int IDW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/comb_sched_core.sv
// Purely combinational compare/select datapath shared by all requesters.
// All operands and results are unsigned and SIZE bits wide.
module comb_core #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] s1,
    input  logic [SIZE-1:0] s2,
    input  logic [SIZE-1:0] s3,
    output logic [SIZE-1:0] o1,
    output logic [SIZE-1:0] o2,
    output logic [SIZE-1:0] o3,
    output logic [SIZE-1:0] o4,
    output logic [SIZE-1:0] o5
);

    logic [2:0] lsbs;

    always_comb begin
        lsbs = {s3[0], s2[0], s1[0]};
        o1   = s1;
        o2   = s2;
        o3   = s1;
        o4   = s2;
        o5   = s1;
        if (s1 < s2) begin
            o3 = s2;
            o5 = s3;
            if (lsbs == 3'd1) begin
                o1 = s3;
                o2 = s3;
                o4 = s3;
            end else if (lsbs == 3'd3) begin
                o3 = '0;
                o4 = '0;
            end else begin
                o4 = s1;
            end
        end
    end

endmodule

// File: rtl/comb_sched.sv
// Round-robin scheduler in front of one shared comb_core: grants a requester,
// latches its operands, evaluates them and holds the tagged result until accepted.
module comb_sched
    import comb_sched_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] src1_in,
    input  logic [NREQ*SIZE-1:0] src2_in,
    input  logic [NREQ*SIZE-1:0] src3_in,
    output logic [NREQ-1:0]      grant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic [SIZE-1:0]      out1,
    output logic [SIZE-1:0]      out2,
    output logic [SIZE-1:0]      out3,
    output logic [SIZE-1:0]      out4,
    output logic [SIZE-1:0]      out5
);

    // Handshake: a result transfers on any cycle where out_valid && out_ready;
    // once out_valid rises, out_id and out1..out5 stay frozen until that cycle.

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [SIZE-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             out_valid_q, out_valid_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    logic [SIZE-1:0]  out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
    logic [SIZE-1:0]  out4_q, out4_d, out5_q, out5_d;

    logic [SIZE-1:0]  c1, c2, c3, c4, c5;
    logic             found;
    logic [IDW-1:0]   win;
    int               idx;

    comb_core #(.SIZE(SIZE)) u_core (
        .s1(s1_q), .s2(s2_q), .s3(s3_q),
        .o1(c1), .o2(c2), .o3(c3), .o4(c4), .o5(c5)
    );

    // First active requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out1_d      = out1_q;
        out2_d      = out2_q;
        out3_d      = out3_q;
        out4_d      = out4_q;
        out5_d      = out5_q;
        grant       = '0;
        case (state_q)
            ST_IDLE: begin
                if (found && !reset) begin
                    grant   = NREQ'(1) << win;
                    id_d    = win;
                    s1_d    = src1_in[int'(win)*SIZE +: SIZE];
                    s2_d    = src2_in[int'(win)*SIZE +: SIZE];
                    s3_d    = src3_in[int'(win)*SIZE +: SIZE];
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                out1_d      = c1;
                out2_d      = c2;
                out3_d      = c3;
                out4_d      = c4;
                out5_d      = c5;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rr_ptr_d    = (int'(id_q) + 1 >= NREQ) ? '0 : id_q + 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            out4_q      <= '0;
            out5_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out1_q      <= out1_d;
            out2_q      <= out2_d;
            out3_q      <= out3_d;
            out4_q      <= out4_d;
            out5_q      <= out5_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out3      = out3_q;
    assign out4      = out4_q;
    assign out5      = out5_q;

endmodule

// File: tb/tb_comb_sched.sv
// Directed bench for comb_sched (SIZE=4, NREQ=2) with hand-computed results.
module tb_comb_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [7:0] src1_in, src2_in, src3_in;
    logic [1:0] grant;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_id;
    logic [3:0] out1, out2, out3, out4, out5;

    int checks   = 0;
    int failures = 0;

    comb_sched #(.SIZE(4), .NREQ(2)) dut (
        .clk(clk), .reset(reset), .req(req),
        .src1_in(src1_in), .src2_in(src2_in), .src3_in(src3_in),
        .grant(grant), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c);
        src1_in[idx*4 +: 4] = a;
        src2_in[idx*4 +: 4] = b;
        src3_in[idx*4 +: 4] = c;
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] id,
                            input logic [3:0] e1, input logic [3:0] e2,
                            input logic [3:0] e3, input logic [3:0] e4,
                            input logic [3:0] e5);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_id"}, out_id, id);
        chk({tag, "_o1"}, out1, e1);
        chk({tag, "_o2"}, out2, e2);
        chk({tag, "_o3"}, out3, e3);
        chk({tag, "_o4"}, out4, e4);
        chk({tag, "_o5"}, out5, e5);
    endtask

    // Single-requester transaction: grant, two cycles to valid, then accept.
    task automatic run_op(input string tag, input int idx,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] e1, input logic [3:0] e2,
                          input logic [3:0] e3, input logic [3:0] e4,
                          input logic [3:0] e5);
        int n;
        set_ops(idx, a, b, c);
        req = 2'b01 << idx;
        #1;
        n = 0;
        while (grant == 2'b00 && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_grant"}, grant, 2'b01 << idx);
        step();
        req = 2'b00;
        chk({tag, "_eval_valid"}, out_valid, 0);
        step();
        chk_outs(tag, 2'(idx), e1, e2, e3, e4, e5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_accepted"}, out_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 2'b11;
        out_ready = 1'b0;
        src1_in   = '0;
        src2_in   = '0;
        src3_in   = '0;
        set_ops(0, 4'd1, 4'd3, 4'd5);
        set_ops(1, 4'd7, 4'd2, 4'd9);

        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_id", out_id, 0);
        chk("rst_outs", {out1, out2, out3, out4, out5}, 0);

        // Default arm on req0, latency grant -> valid = 2 cycles.
        reset = 1'b0;
        #1;
        chk("first_grant", grant, 2'b01);
        step();
        req = 2'b00;
        chk("dflt_eval_grant", grant, 0);
        chk("dflt_eval_valid", out_valid, 0);
        step();
        chk_outs("dflt", 2'd0, 4'd1, 4'd3, 4'd3, 4'd1, 4'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("dflt_accepted", out_valid, 0);
        chk("dflt_idle_grant", grant, 0);

        // out_ready while idle is ignored.
        out_ready = 1'b1;
        step();
        chk("idle_ready_valid", out_valid, 0);
        out_ready = 1'b0;

        run_op("lsbs1", 1, 4'd1, 4'd4, 4'd6, 4'd6, 4'd6, 4'd4, 4'd6, 4'd6);
        run_op("lsbs3", 0, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd0, 4'd0, 4'd2);
        run_op("ge",    1, 4'd7, 4'd2, 4'd9, 4'd7, 4'd2, 4'd7, 4'd2, 4'd7);
        run_op("wrap",  1, 4'd15, 4'd15, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15);

        // Fairness: rr_ptr is 0 here, both requesting, consumer always ready.
        set_ops(0, 4'd1, 4'd3, 4'd5);
        set_ops(1, 4'd7, 4'd2, 4'd9);
        out_ready = 1'b1;
        req       = 2'b11;
        #1;
        chk("fair0_grant", grant, 2'b01);
        step();
        chk("fair0_eval_grant", grant, 0);
        step();
        chk_outs("fair0", 2'd0, 4'd1, 4'd3, 4'd3, 4'd1, 4'd5);
        step();
        chk("fair1_grant", grant, 2'b10);
        step();
        step();
        chk_outs("fair1", 2'd1, 4'd7, 4'd2, 4'd7, 4'd2, 4'd7);
        step();
        chk("fair2_grant", grant, 2'b01);
        step();
        step();
        chk_outs("fair2", 2'd0, 4'd1, 4'd3, 4'd3, 4'd1, 4'd5);

        // Backpressure: hold the result for 5 cycles with req still asserted.
        out_ready = 1'b0;
        req       = 2'b01;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_grant", grant, 0);
            chk("bp_outs", {out_id, out1, out2, out3, out4, out5}, {2'd0, 20'h13315});
        end

        // Reset in HOLD discards the result even with out_ready raised.
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("hrst_valid", out_valid, 0);
        chk("hrst_grant", grant, 0);
        chk("hrst_outs", {out_id, out1, out2, out3, out4, out5}, 0);
        reset     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("hrst_regrant", grant, 2'b01);
        step();
        req = 2'b00;
        chk("hrst_eval_valid", out_valid, 0);
        step();
        chk_outs("hrst_op", 2'd0, 4'd1, 4'd3, 4'd3, 4'd1, 4'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hrst_accepted", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
